spad_trig_gen: RTL and testbench

//  Synthesizable SPAD-side front end that drives the TDC event interface.

---
 rtl/spad_trig_gen.sv | 107 ++++++++++
 tb/tb_spad_trig_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spad_trig_gen.sv
// SPAD front end: synchronises the photon edge, fires the TDC trigger and time gate,
// captures the pixel map and stays locked until the TDC quenches via rst_auto.
module spad_trig_gen #(
  parameter int GATE_CYC = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_auto,
  input  logic             arm_en,
  input  logic             photon,
  input  logic [15:0]      pix_i,
  output logic             trig,
  output logic             time_gate,
  output logic [15:0]      pix_o,
  output logic             busy,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_GATE  = 2'd2;
  localparam logic [1:0] ST_LOCK  = 2'd3;

  localparam logic [7:0]       GCNT_LOAD = 8'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic       photon_p0, photon_p1, photon_p2;
  logic       rise;
  logic [1:0] state, state_nxt;
  logic [7:0] gcnt;
  logic       load_gate, end_gate;
  logic       in_busy;

  assign rise    = photon_p1 & ~photon_p2;
  assign in_busy = (state == ST_GATE) | (state == ST_LOCK);

  always_comb begin
    state_nxt = state;
    load_gate = 1'b0;
    end_gate  = 1'b0;
    case (state)
      ST_IDLE:  if (arm_en) state_nxt = ST_ARMED;
      // arm_en wins over a coincident rise, so a disarm drops the event
      ST_ARMED: begin
        if (!arm_en) begin
          state_nxt = ST_IDLE;
        end else if (rise) begin
          state_nxt = ST_GATE;
          load_gate = 1'b1;
        end
      end
      ST_GATE: begin
        if (gcnt == 8'd0) begin
          state_nxt = ST_LOCK;
          end_gate  = 1'b1;
        end
      end
      ST_LOCK:  state_nxt = ST_LOCK;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0..p2: photon synchroniser, preset high so a level held through reset is not an edge
  always_ff @(posedge clk_i or negedge rst_auto) begin
    if (!rst_auto) begin
      photon_p0 <= 1'b1;
      photon_p1 <= 1'b1;
      photon_p2 <= 1'b1;
    end else begin
      photon_p0 <= photon;
      photon_p1 <= photon_p0;
      photon_p2 <= photon_p1;
    end
  end

  // Control stage: state, gate timing, capture and miss counting
  always_ff @(posedge clk_i or negedge rst_auto) begin
    if (!rst_auto) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      trig      <= 1'b0;
      time_gate <= 1'b0;
      pix_o     <= 16'h0000;
      gcnt      <= 8'd0;
      miss_cnt  <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_GATE) | (state_nxt == ST_LOCK);
      if (load_gate) begin
        trig      <= 1'b1;
        time_gate <= 1'b1;
        pix_o     <= pix_i;
        gcnt      <= GCNT_LOAD;
      end else if (end_gate) begin
        time_gate <= 1'b0;
      end else if (state == ST_GATE) begin
        gcnt <= gcnt - 8'd1;
      end
      if (rise && in_busy) miss_cnt <= sat_inc(miss_cnt);
    end
  end

endmodule

// File: tb/tb_spad_trig_gen.sv
// Directed bench for spad_trig_gen: trigger latency, gate length, lock/miss counting,
// arm gating, reset re-arm behaviour and asynchronous quench.
module tb_spad_trig_gen;

  logic        clk_i;
  logic        rst_auto;
  logic        arm_en;
  logic        photon;
  logic [15:0] pix_i;
  logic        trig;
  logic        time_gate;
  logic [15:0] pix_o;
  logic        busy;
  logic [7:0]  miss_cnt;

  int checks = 0;
  int errors = 0;

  spad_trig_gen #(.GATE_CYC(3), .CNT_W(8)) dut (
    .clk_i     (clk_i),
    .rst_auto  (rst_auto),
    .arm_en    (arm_en),
    .photon    (photon),
    .pix_i     (pix_i),
    .trig      (trig),
    .time_gate (time_gate),
    .pix_o     (pix_o),
    .busy      (busy),
    .miss_cnt  (miss_cnt)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clean photon pulse: a rise is seen by the core on the second edge after it
  task automatic pulse();
    photon = 1'b1;
    step(1);
    photon = 1'b0;
    step(3);
  endtask

  // One-cycle quench followed by enough edges to flush the synchroniser
  task automatic quench();
    rst_auto = 1'b0;
    step(1);
    rst_auto = 1'b1;
    step(3);
  endtask

  initial begin
    rst_auto = 1'b1;
    arm_en   = 1'b0;
    photon   = 1'b0;
    pix_i    = 16'h0000;
    #2 rst_auto = 1'b0;
    #1;
    check("rst_trig", trig, 0);
    check("rst_tgate", time_gate, 0);
    check("rst_pix", pix_o, 0);
    check("rst_busy", busy, 0);
    check("rst_miss", miss_cnt, 0);
    step(2);
    check("rst_hold_trig", trig, 0);

    // Test 1: basic trigger, latency and gate length
    rst_auto = 1'b1;
    arm_en   = 1'b1;
    pix_i    = 16'hA5C3;
    step(4);
    check("t1_idle_trig", trig, 0);
    check("t1_idle_busy", busy, 0);
    photon = 1'b1;
    step(1);
    check("t1_e0_trig", trig, 0);
    step(1);
    check("t1_e1_trig", trig, 0);
    check("t1_e1_tgate", time_gate, 0);
    step(1);
    check("t1_e2_trig", trig, 1);
    check("t1_e2_tgate", time_gate, 1);
    check("t1_e2_pix", pix_o, 16'hA5C3);
    check("t1_e2_busy", busy, 1);
    step(1);
    check("t1_e3_tgate", time_gate, 1);
    step(1);
    check("t1_e4_tgate", time_gate, 1);
    photon = 1'b0;
    step(1);
    check("t1_e5_tgate", time_gate, 0);
    check("t1_e5_trig", trig, 1);
    check("t1_e5_busy", busy, 1);
    check("t1_e5_miss", miss_cnt, 0);
    step(3);

    // Test 2: misses while locked, then quench and re-trigger
    pix_i = 16'h0000;
    pulse();
    check("t2_miss1", miss_cnt, 1);
    pulse();
    check("t2_miss2", miss_cnt, 2);
    check("t2_trig", trig, 1);
    check("t2_pix_hold", pix_o, 16'hA5C3);
    rst_auto = 1'b0;
    #1;
    check("t2_q_trig", trig, 0);
    check("t2_q_pix", pix_o, 0);
    check("t2_q_busy", busy, 0);
    check("t2_q_miss", miss_cnt, 0);
    step(1);
    rst_auto = 1'b1;
    pix_i    = 16'h1234;
    step(3);
    photon = 1'b1;
    step(1);
    photon = 1'b0;
    step(1);
    check("t2_re_e1_trig", trig, 0);
    step(1);
    check("t2_re_trig", trig, 1);
    check("t2_re_tgate", time_gate, 1);
    check("t2_re_pix", pix_o, 16'h1234);
    step(4);

    // Test 3: disarmed photons are ignored and not counted
    arm_en = 1'b0;
    quench();
    pulse();
    step(2);
    check("t3_trig", trig, 0);
    check("t3_tgate", time_gate, 0);
    check("t3_miss", miss_cnt, 0);
    check("t3_busy", busy, 0);

    // Disarm on the same edge the rise is seen: event dropped
    arm_en = 1'b1;
    step(2);
    photon = 1'b1;
    step(2);
    arm_en = 1'b0;
    step(1);
    check("t3_drop_trig", trig, 0);
    check("t3_drop_busy", busy, 0);
    photon = 1'b0;
    step(3);

    // Test 4: photon held through reset never triggers; a fresh rise does
    arm_en   = 1'b1;
    photon   = 1'b1;
    rst_auto = 1'b0;
    step(1);
    rst_auto = 1'b1;
    step(6);
    check("t4_held_trig", trig, 0);
    check("t4_held_busy", busy, 0);
    photon = 1'b0;
    step(2);
    photon = 1'b1;
    step(2);
    check("t4_e1_trig", trig, 0);
    step(1);
    check("t4_trig", trig, 1);
    photon = 1'b0;
    step(6);
    check("t4_lock_tgate", time_gate, 0);
    check("t4_miss0", miss_cnt, 0);

    // Test 5: miss counter saturation
    for (int i = 0; i < 254; i++) pulse();
    check("t5_miss254", miss_cnt, 254);
    pulse();
    check("t5_miss255", miss_cnt, 255);
    for (int i = 0; i < 45; i++) pulse();
    check("t5_sat", miss_cnt, 255);
    check("t5_trig", trig, 1);

    // Test 6: quench in the second GATE cycle drops outputs before the next edge
    quench();
    photon = 1'b1;
    step(3);
    check("t6_gate1_tgate", time_gate, 1);
    step(1);
    check("t6_gate2_tgate", time_gate, 1);
    #2 rst_auto = 1'b0;
    #1;
    check("t6_async_tgate", time_gate, 0);
    check("t6_async_trig", trig, 0);
    check("t6_async_busy", busy, 0);
    step(1);
    rst_auto = 1'b1;
    photon   = 1'b0;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
